// File: rtl/gcd_lcm_stein.sv
// gcd_lcm_stein: handshaked GCD (binary/Stein reduction) with optional LCM
// (restoring division of A by the GCD, then one multiply by B).
// Optional feature macro: GCD_LCM_LCM_EN enables the DIV state, the a0/b0
// operand copies, the divider, the multiplier and the lcm_out port.
module gcd_lcm_stein #(
  parameter int unsigned DATAWIDTH = 8,
  localparam int unsigned CNTW = $clog2(DATAWIDTH + 1)
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATAWIDTH-1:0]   A,
  input  logic [DATAWIDTH-1:0]   B,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATAWIDTH-1:0]   gcd_out
`ifdef GCD_LCM_LCM_EN
  ,
  output logic [2*DATAWIDTH-1:0] lcm_out
`endif
);

  localparam int unsigned W = DATAWIDTH;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SHIFT  = 3'd1,
    S_REDUCE = 3'd2,
`ifdef GCD_LCM_LCM_EN
    S_DIV    = 3'd3,
`endif
    S_OUT    = 3'd4
  } state_t;

  state_t r_state;
  state_t w_next_state;

  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [CNTW-1:0] r_k;
  logic [W-1:0]    r_gcd;
  logic            r_out_valid;
  logic            r_in_ready;

  logic w_accept;
  logic w_zero_op;

  assign w_accept  = in_valid && r_in_ready;
  assign w_zero_op = (A == '0) || (B == '0);

`ifdef GCD_LCM_LCM_EN
  logic [W-1:0]     r_a0;
  logic [W-1:0]     r_b0;
  logic [W-1:0]     r_g;
  logic [W:0]       r_rem;
  logic [W-1:0]     r_q;
  logic [CNTW-1:0]  r_cnt;
  logic [2*W-1:0]   r_lcm;

  logic [W+1:0]     w_shift;
  logic [W+1:0]     w_diff;
  logic             w_borrow;
  logic [W:0]       w_rem_nxt;
  logic [W-1:0]     w_q_nxt;
  logic [2*W-1:0]   w_prod;
  logic             w_div_last;

  // One restoring-division step: shift in the next dividend bit, trial-subtract g
  assign w_shift    = {r_rem, r_q[W-1]};
  assign w_diff     = w_shift - (W+2)'(r_g);
  assign w_borrow   = w_diff[W+1];
  assign w_rem_nxt  = w_borrow ? w_shift[W:0] : w_diff[W:0];
  assign w_q_nxt    = {r_q[W-2:0], ~w_borrow};
  assign w_prod     = (2*W)'(w_q_nxt) * (2*W)'(r_b0);
  assign w_div_last = (r_cnt == CNTW'(W - 1));

  assign lcm_out = r_lcm;
`endif

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign gcd_out   = r_gcd;

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_next_state = w_zero_op ? S_OUT : S_SHIFT;
      end
      S_SHIFT: begin
        if (r_a[0] || r_b[0]) w_next_state = S_REDUCE;
      end
      S_REDUCE: begin
`ifdef GCD_LCM_LCM_EN
        if (r_a == r_b) w_next_state = S_DIV;
`else
        if (r_a == r_b) w_next_state = S_OUT;
`endif
      end
`ifdef GCD_LCM_LCM_EN
      S_DIV: begin
        if (w_div_last) w_next_state = S_OUT;
      end
`endif
      S_OUT: begin
        if (out_ready) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Handshake flags track the state being entered
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_in_ready  <= (w_next_state == S_IDLE);
      r_out_valid <= (w_next_state == S_OUT);
    end
  end

  // Stein reduction datapath and result capture
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_a   <= '0;
      r_b   <= '0;
      r_k   <= '0;
      r_gcd <= '0;
`ifdef GCD_LCM_LCM_EN
      r_a0  <= '0;
      r_b0  <= '0;
      r_g   <= '0;
      r_rem <= '0;
      r_q   <= '0;
      r_cnt <= '0;
      r_lcm <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_a <= A;
            r_b <= B;
            r_k <= '0;
`ifdef GCD_LCM_LCM_EN
            r_a0 <= A;
            r_b0 <= B;
`endif
            if (w_zero_op) begin
              r_gcd <= A | B;
`ifdef GCD_LCM_LCM_EN
              r_lcm <= '0;
`endif
            end
          end
        end
        S_SHIFT: begin
          if (!r_a[0] && !r_b[0]) begin
            r_a <= r_a >> 1;
            r_b <= r_b >> 1;
            r_k <= r_k + CNTW'(1);
          end
        end
        S_REDUCE: begin
          if (r_a == r_b) begin
`ifdef GCD_LCM_LCM_EN
            r_g   <= r_a << r_k;
            r_rem <= '0;
            r_q   <= r_a0;
            r_cnt <= '0;
`else
            r_gcd <= r_a << r_k;
`endif
          end else if (!r_a[0]) begin
            r_a <= r_a >> 1;
          end else if (!r_b[0]) begin
            r_b <= r_b >> 1;
          end else if (r_a > r_b) begin
            r_a <= (r_a - r_b) >> 1;
          end else begin
            r_b <= (r_b - r_a) >> 1;
          end
        end
`ifdef GCD_LCM_LCM_EN
        S_DIV: begin
          r_rem <= w_rem_nxt;
          r_q   <= w_q_nxt;
          r_cnt <= r_cnt + CNTW'(1);
          if (w_div_last) begin
            r_gcd <= r_g;
            r_lcm <= w_prod;
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_lcm_stein.sv
// Directed + randomized bench for gcd_lcm_stein against an Euclid-based model.
module tb_gcd_lcm_stein;

  localparam int unsigned W = 8;
`ifdef GCD_LCM_LCM_EN
  localparam int BOUND = 4*W + 1;
`else
  localparam int BOUND = 3*W + 1;
`endif

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] gcd_out;
`ifdef GCD_LCM_LCM_EN
  logic [2*W-1:0] lcm_out;
`endif

  int n_vec = 0;
  int n_err = 0;

  gcd_lcm_stein #(.DATAWIDTH(W)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .gcd_out   (gcd_out)
`ifdef GCD_LCM_LCM_EN
    ,
    .lcm_out   (lcm_out)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] ref_gcd(input logic [W-1:0] a, input logic [W-1:0] b);
    int x = int'(a);
    int y = int'(b);
    int t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return W'(x);
  endfunction

  function automatic logic [2*W-1:0] ref_lcm(input logic [W-1:0] a, input logic [W-1:0] b);
    longint p;
    if (a == 0 || b == 0) return '0;
    p = (longint'(a) * longint'(b)) / longint'(ref_gcd(a, b));
    return (2*W)'(p);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for in_ready, then present operands for one accepting edge
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
    int n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("ready_timeout", 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    A = a;
    B = b;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Count negedges after the accept edge until out_valid is seen
  task automatic wait_out(output int lat);
    lat = 0;
    forever begin
      @(negedge clk);
      lat++;
      if (out_valid || lat >= 200) break;
    end
    if (!out_valid) chk("out_timeout", 64'(out_valid), 64'd1);
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
    int lat;
    start_op(a, b);
    wait_out(lat);
    chk({tag, ".gcd"}, 64'(gcd_out), 64'(ref_gcd(a, b)));
`ifdef GCD_LCM_LCM_EN
    chk({tag, ".lcm"}, 64'(lcm_out), 64'(ref_lcm(a, b)));
`endif
    if (a == 0 || b == 0) chk({tag, ".lat"}, 64'(lat), 64'd1);
    else                  chk({tag, ".lat_ok"}, 64'(lat <= BOUND), 64'd1);
    @(negedge clk);
    chk({tag, ".valid_drop"}, 64'(out_valid), 64'd0);
    chk({tag, ".ready_back"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    int lat;
    logic [W-1:0] ra, rb;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst.in_ready", 64'(in_ready), 64'd0);
    chk("rst.out_valid", 64'(out_valid), 64'd0);
    chk("rst.gcd", 64'(gcd_out), 64'd0);
`ifdef GCD_LCM_LCM_EN
    chk("rst.lcm", 64'(lcm_out), 64'd0);
`endif
    rstn = 1'b1;
    @(negedge clk);
    chk("rel.in_ready", 64'(in_ready), 64'd1);

    // Directed cases
    run_op("g12_18", 8'd12, 8'd18);
    run_op("g0_7", 8'd0, 8'd7);
    run_op("g0_0", 8'd0, 8'd0);
    run_op("g128_96", 8'd128, 8'd96);
    run_op("g255_254", 8'd255, 8'd254);
    run_op("g48_36", 8'd48, 8'd36);

    // Backpressure: result held, busy in_valid ignored
    out_ready = 1'b0;
    start_op(8'd9, 8'd6);
    wait_out(lat);
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      A = 8'd1;
      B = 8'd1;
      @(negedge clk);
      chk("bp.valid", 64'(out_valid), 64'd1);
      chk("bp.gcd", 64'(gcd_out), 64'd3);
`ifdef GCD_LCM_LCM_EN
      chk("bp.lcm", 64'(lcm_out), 64'd18);
`endif
      chk("bp.in_ready", 64'(in_ready), 64'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp.valid_drop", 64'(out_valid), 64'd0);
    chk("bp.ready_back", 64'(in_ready), 64'd1);
    @(negedge clk);
    chk("bp.no_extra", 64'(out_valid), 64'd0);
    chk("bp.gcd_hold", 64'(gcd_out), 64'd3);

    // Reset in the middle of an operation
    start_op(8'd200, 8'd150);
    repeat (3) @(negedge clk);
    rstn = 1'b0;
    #1;
    chk("mid_rst.valid", 64'(out_valid), 64'd0);
    chk("mid_rst.gcd", 64'(gcd_out), 64'd0);
    chk("mid_rst.in_ready", 64'(in_ready), 64'd0);
`ifdef GCD_LCM_LCM_EN
    chk("mid_rst.lcm", 64'(lcm_out), 64'd0);
`endif
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk("mid_rst.ready_back", 64'(in_ready), 64'd1);
    run_op("g5_5", 8'd5, 8'd5);

    // Randomized operands, occasional zeros
    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom_range(0, 255));
      rb = W'($urandom_range(0, 255));
      if ($urandom_range(0, 9) == 0) ra = '0;
      if ($urandom_range(0, 9) == 0) rb = '0;
      run_op("rand", ra, rb);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
